// File: rtl/rsp_tone_gen.sv
// rsp_tone_gen: stepped-tone stimulus generator for the RSP input.
// Streams a blanking segment followed by three stepped tones on a
// valid/ready port. Each tone is an 8-step sine or a 4-step square.
// Optional LFSR dither on out_data_o[0]: define RSP_TONEGEN_DITHER_EN.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   start_i/stop_i  one-cycle run control pulses
//   hold*_i         per-tone step hold (hold+1 samples per step)
//   shape_i         per-tone select, 0 sine, 1 square
//   *_len_i         blank/tone0/tone1 segment lengths in samples
//   out_*           sample stream (valid/ready, data, segment tag)
//   busy_o          run in progress
module rsp_tone_gen #(
  parameter int DATA_W = 16,
  parameter int HOLD_W = 10,
  parameter int SEG_W  = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [HOLD_W-1:0] hold0_i,
  input  logic [HOLD_W-1:0] hold1_i,
  input  logic [HOLD_W-1:0] hold2_i,
  input  logic [2:0]        shape_i,
  input  logic [SEG_W-1:0]  blank_len_i,
  input  logic [SEG_W-1:0]  seg0_len_i,
  input  logic [SEG_W-1:0]  seg1_len_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        out_seg_o,
  output logic              busy_o
);

  // Two guard bits: the sum of three lengths never overflows.
  localparam int NW = SEG_W + 2;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e                 state_q, state_d;
  logic                   pend_q, pend_d;
  logic                   valid_q, valid_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic [1:0]             seg_q, seg_d;
  logic [NW-1:0]          n_q, n_d;
  logic [2:0][HOLD_W-1:0] hold_q, hold_d;
  logic [2:0]             shape_q, shape_d;
  logic [2:0][NW-1:0]     bnd_q, bnd_d;
  logic [2:0][HOLD_W-1:0] cnt_q, cnt_d;
  logic [2:0][2:0]        idx_q, idx_d;
  logic [2:0][NW-1:0]     bnd_in;
  logic signed [15:0]     tone_v;
  logic                   acc;

`ifdef RSP_TONEGEN_DITHER_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  logic [15:0] lfsr_q, lfsr_d;
`endif

  // Segment boundaries are kept cumulative so the
  // segment of sample n is three compares.
  function automatic logic [1:0] seg_of(
    input logic [NW-1:0]      n,
    input logic [2:0][NW-1:0] bnd
  );
    logic [1:0] s;
    if (n < bnd[0])      s = 2'd0;
    else if (n < bnd[1]) s = 2'd1;
    else if (n < bnd[2]) s = 2'd2;
    else                 s = 2'd3;
    return s;
  endfunction

  function automatic logic signed [15:0] tbl(
    input logic       sq,
    input logic [2:0] i
  );
    logic signed [15:0] v;
    v = '0;
    if (sq) begin
      unique case (i[1:0])
        2'd1:    v = 16'sd32767;
        2'd3:    v = 16'sh8000;
        default: v = '0;
      endcase
    end else begin
      unique case (i)
        3'd1, 3'd3: v = 16'sd23170;
        3'd2:       v = 16'sd32767;
        3'd5, 3'd7: v = -16'sd23170;
        3'd6:       v = 16'sh8000;
        default:    v = '0;
      endcase
    end
    return v;
  endfunction

  // Truncating arithmetic shift: no rounding.
  function automatic logic [DATA_W-1:0] scale(
    input logic signed [15:0] v
  );
    logic signed [15:0] s;
    s = v >>> (16 - DATA_W);
    return s[DATA_W-1:0];
  endfunction

  always_comb begin
    bnd_in    = '0;
    bnd_in[0] = NW'(blank_len_i);
    bnd_in[1] = bnd_in[0] + NW'(seg0_len_i);
    bnd_in[2] = bnd_in[1] + NW'(seg1_len_i);
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    valid_d = valid_q;
    data_d  = data_q;
    seg_d   = seg_q;
    n_d     = n_q;
    hold_d  = hold_q;
    shape_d = shape_q;
    bnd_d   = bnd_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    tone_v  = '0;
`ifdef RSP_TONEGEN_DITHER_EN
    lfsr_d  = lfsr_q;
`endif
    acc = valid_q && out_ready_i;

    unique case (state_q)
      IDLE: begin
        if (start_i && !stop_i) begin
          state_d = RUN;
          valid_d = 1'b1;
          pend_d  = 1'b0;
          hold_d  = {hold2_i, hold1_i, hold0_i};
          shape_d = shape_i;
          bnd_d   = bnd_in;
          n_d     = '0;
          cnt_d   = '0;
          idx_d   = '0;
          seg_d   = seg_of('0, bnd_in);
          // Every table entry 0 is zero.
          data_d  = '0;
`ifdef RSP_TONEGEN_DITHER_EN
          lfsr_d    = LFSR_SEED;
          data_d[0] = LFSR_SEED[0];
`endif
        end
      end
      RUN: begin
        if (acc) begin
          if (n_q < bnd_q[2]) n_d = n_q + 1'b1;
          for (int k = 0; k < 3; k++) begin
            if (cnt_q[k] == hold_q[k]) begin
              cnt_d[k] = '0;
              if (shape_q[k])
                idx_d[k] = {1'b0, idx_q[k][1:0] + 2'd1};
              else
                idx_d[k] = idx_q[k] + 3'd1;
            end else begin
              cnt_d[k] = cnt_q[k] + 1'b1;
            end
          end
          seg_d = seg_of(n_d, bnd_q);
          unique case (seg_d)
            2'd1:    tone_v = tbl(shape_q[0], idx_d[0]);
            2'd2:    tone_v = tbl(shape_q[1], idx_d[1]);
            2'd3:    tone_v = tbl(shape_q[2], idx_d[2]);
            default: tone_v = '0;
          endcase
          data_d = scale(tone_v);
`ifdef RSP_TONEGEN_DITHER_EN
          lfsr_d = {lfsr_q[14:0],
                    lfsr_q[15] ^ lfsr_q[13] ^
                    lfsr_q[12] ^ lfsr_q[10]};
          data_d[0] = data_d[0] ^ lfsr_d[0];
`endif
        end
        // valid is always high in RUN, so ready means the
        // presented sample completes on this edge.
        if ((stop_i || pend_q) && out_ready_i) begin
          state_d = IDLE;
          valid_d = 1'b0;
          pend_d  = 1'b0;
          data_d  = '0;
          seg_d   = '0;
        end else if (stop_i) begin
          pend_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      seg_q   <= '0;
      n_q     <= '0;
      hold_q  <= '0;
      shape_q <= '0;
      bnd_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
`ifdef RSP_TONEGEN_DITHER_EN
      lfsr_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      seg_q   <= seg_d;
      n_q     <= n_d;
      hold_q  <= hold_d;
      shape_q <= shape_d;
      bnd_q   <= bnd_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
`ifdef RSP_TONEGEN_DITHER_EN
      lfsr_q  <= lfsr_d;
`endif
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_seg_o   = seg_q;
  assign busy_o      = (state_q == RUN);

endmodule
